sram_sync: RTL and testbench

//   Parametrised synchronous single-port SRAM model for CPU-side work RAM
//   (e.g. uPD7800 internal RAM at 'hFF80-'hFFFF, cart RAM), usable in sim and synthesis.

---
 rtl/sram_sync.sv | 125 ++++++++++++
 tb/tb_sram_sync.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sync.sv
// Synchronous single-port work RAM with a pipelined read path (RD_LAT stages) and a
// registered output enable. Define SRAM_CLEAR_EN to add the FILL sweep on reset and on CLR.
module sram_sync #(
  parameter int              AW     = 7,
  parameter int              DW     = 8,
  parameter int              RD_LAT = 1,
  parameter logic [DW-1:0]   FILL   = '0
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          nCE,
  input  logic          nWE,
  input  logic          nOE,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] DI,
  input  logic          CLR,
  output logic [DW-1:0] DO,
  output logic          DO_OE,
  output logic          READY,
  output logic          dbg_sweep
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] pipe_d [RD_LAT];
  logic          pipe_v [RD_LAT];

  logic          sw_wr;
  logic [AW-1:0] sw_addr;
  logic          flush;
  logic          cpu_wr;
  logic          cpu_rd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

`ifdef SRAM_CLEAR_EN
  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t        state;
  logic [AW:0]   ctr;
  logic          ready_q;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state   <= ST_SWEEP;
      ctr     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_SWEEP: begin
          // CLR is deliberately ignored here: a sweep always runs to completion.
          ctr <= ctr + 1'b1;
          if (ctr == (AW+1)'(DEPTH - 1)) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (CLR) begin
            state   <= ST_SWEEP;
            ctr     <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_SWEEP;
          ctr     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Gate with RESETB so holding reset never writes the array.
  assign sw_wr     = (state == ST_SWEEP) && RESETB;
  assign sw_addr   = ctr[AW-1:0];
  assign flush     = (state == ST_RUN) && CLR;
  assign READY     = ready_q;
  assign dbg_sweep = (state == ST_SWEEP);
`else
  logic unused_clr;

  assign unused_clr = CLR;
  assign sw_wr      = 1'b0;
  assign sw_addr    = '0;
  assign flush      = 1'b0;
  assign READY      = 1'b1;
  assign dbg_sweep  = 1'b0;
`endif

  // A write with nOE low is still only a write: a read requires nWE high.
  assign cpu_wr  = READY && !nCE && !nWE;
  assign cpu_rd  = READY && !nCE && nWE && !nOE;
  assign wr_en   = sw_wr || cpu_wr;
  assign wr_addr = sw_wr ? sw_addr : A;
  assign wr_data = sw_wr ? FILL : DI;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage 0 captures the pre-write array word, giving read-before-write on collisions.
  // Data stages only advance with a valid read, so DO holds the last delivered word.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
        pipe_v[i] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= cpu_rd && !flush;
      if (cpu_rd) pipe_d[0] <= mem[A];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1] && !flush;
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign DO    = pipe_d[RD_LAT-1];
  assign DO_OE = pipe_v[RD_LAT-1];

endmodule

// File: tb/tb_sram_sync.sv
// Directed bench for sram_sync: three instances (RD_LAT 1/2/3) share one stimulus bus.
// Sweep/CLR scenarios run when SRAM_CLEAR_EN is defined, the no-clear scenario otherwise.
module tb_sram_sync;
  localparam int AW = 7;
  localparam int DW = 8;
`ifdef SRAM_CLEAR_EN
  localparam logic EXP_RDY_RST = 1'b0;
`else
  localparam logic EXP_RDY_RST = 1'b1;
`endif

  logic          CLK    = 1'b0;
  logic          RESETB = 1'b0;
  logic          nCE    = 1'b1;
  logic          nWE    = 1'b1;
  logic          nOE    = 1'b1;
  logic          CLR    = 1'b0;
  logic [AW-1:0] A      = '0;
  logic [DW-1:0] DI     = '0;

  logic [DW-1:0] do1, do2, do3;
  logic          oe1, oe2, oe3;
  logic          rdy1, rdy2, rdy3;
  logic          dbg1, dbg2, dbg3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  sram_sync #(.AW(AW), .DW(DW), .RD_LAT(1), .FILL(8'h5A)) u1 (
    .CLK(CLK), .RESETB(RESETB), .nCE(nCE), .nWE(nWE), .nOE(nOE), .A(A), .DI(DI),
    .CLR(CLR), .DO(do1), .DO_OE(oe1), .READY(rdy1), .dbg_sweep(dbg1));
  sram_sync #(.AW(AW), .DW(DW), .RD_LAT(2), .FILL(8'h00)) u2 (
    .CLK(CLK), .RESETB(RESETB), .nCE(nCE), .nWE(nWE), .nOE(nOE), .A(A), .DI(DI),
    .CLR(CLR), .DO(do2), .DO_OE(oe2), .READY(rdy2), .dbg_sweep(dbg2));
  sram_sync #(.AW(AW), .DW(DW), .RD_LAT(3), .FILL(8'h00)) u3 (
    .CLK(CLK), .RESETB(RESETB), .nCE(nCE), .nWE(nWE), .nOE(nOE), .A(A), .DI(DI),
    .CLR(CLR), .DO(do3), .DO_OE(oe3), .READY(rdy3), .dbg_sweep(dbg3));

  // Driver tasks: called right after a negedge, the next posedge samples them.
  task automatic drive_idle();
    nCE = 1'b1; nWE = 1'b1; nOE = 1'b1;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    nCE = 1'b0; nWE = 1'b0; nOE = 1'b1; A = a; DI = d;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    nCE = 1'b0; nWE = 1'b1; nOE = 1'b0; A = a;
  endtask

  task automatic test_reset();
    RESETB = 1'b0; CLR = 1'b0; drive_idle();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({do1, do2, do3} !== 24'h0) begin
      n_bad++; $display("FAIL reset_do: got %h/%h/%h want 00/00/00", do1, do2, do3);
    end
    n_cmp++;
    if ({oe1, oe2, oe3} !== 3'b000) begin
      n_bad++; $display("FAIL reset_oe: got %b%b%b want 000", oe1, oe2, oe3);
    end
    n_cmp++;
    if ({rdy1, rdy2, rdy3} !== {3{EXP_RDY_RST}}) begin
      n_bad++; $display("FAIL reset_ready: got %b%b%b want %b", rdy1, rdy2, rdy3, {3{EXP_RDY_RST}});
    end
  endtask

  task automatic test_rd_lat1();
    drive_write(7'h12, 8'hA5); @(negedge CLK);
    drive_read(7'h12);         @(negedge CLK);
    drive_idle();
    n_cmp++;
    if (oe1 !== 1'b1 || do1 !== 8'hA5) begin
      n_bad++; $display("FAIL lat1_read: got oe=%b do=%h want oe=1 do=a5", oe1, do1);
    end
    @(negedge CLK);
    n_cmp++;
    if (oe1 !== 1'b0 || do1 !== 8'hA5) begin
      n_bad++; $display("FAIL lat1_hold: got oe=%b do=%h want oe=0 do=a5", oe1, do1);
    end
    n_cmp++;
    if (oe2 !== 1'b1 || do2 !== 8'hA5) begin
      n_bad++; $display("FAIL lat2_read: got oe=%b do=%h want oe=1 do=a5", oe2, do2);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got_d [3];
    logic          got_v [3];
    for (int i = 0; i < 4; i++) begin
      drive_write(AW'(i), 8'h10 + 8'(i)); @(negedge CLK);
    end
    drive_idle(); @(negedge CLK);
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive_read(AW'(c)); else drive_idle();
      @(negedge CLK);
      got_d = '{do1, do2, do3};
      got_v = '{oe1, oe2, oe3};
      // After c+1 posedges a latency-L instance shows read number c+1-L.
      for (int l = 1; l <= 3; l++) begin
        int k;
        k = c + 1 - l;
        n_cmp++;
        if (k >= 0 && k < 4) begin
          if (got_v[l-1] !== 1'b1 || got_d[l-1] !== 8'h10 + 8'(k)) begin
            n_bad++;
            $display("FAIL b2b_lat%0d cyc%0d: got oe=%b do=%h want oe=1 do=%h",
                     l, c + 1, got_v[l-1], got_d[l-1], 8'h10 + 8'(k));
          end
        end else if (got_v[l-1] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_lat%0d cyc%0d: got oe=%b want oe=0", l, c + 1, got_v[l-1]);
        end
      end
    end
  endtask

  task automatic test_collision();
    drive_write(7'h20, 8'h11); @(negedge CLK);
    drive_idle();              @(negedge CLK);
    drive_read(7'h20);         @(negedge CLK);
    n_cmp++;
    if (oe1 !== 1'b1 || do1 !== 8'h11) begin
      n_bad++; $display("FAIL coll_lat1: got oe=%b do=%h want oe=1 do=11", oe1, do1);
    end
    drive_write(7'h20, 8'h22); @(negedge CLK);
    n_cmp++;
    if (oe2 !== 1'b1 || do2 !== 8'h11) begin
      n_bad++; $display("FAIL coll_lat2: got oe=%b do=%h want oe=1 do=11", oe2, do2);
    end
    drive_idle(); @(negedge CLK);
    n_cmp++;
    if (oe3 !== 1'b1 || do3 !== 8'h11) begin
      n_bad++; $display("FAIL coll_lat3: got oe=%b do=%h want oe=1 do=11", oe3, do3);
    end
    drive_read(7'h20); @(negedge CLK);
    drive_idle();
    n_cmp++;
    if (oe1 !== 1'b1 || do1 !== 8'h22) begin
      n_bad++; $display("FAIL coll_reread: got oe=%b do=%h want oe=1 do=22", oe1, do1);
    end
    repeat (3) @(negedge CLK);
    // Selected but output disabled: nothing may enter the pipeline.
    nCE = 1'b0; nWE = 1'b1; nOE = 1'b1; A = 7'h20;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({oe1, oe2, oe3} !== 3'b000) begin
        n_bad++; $display("FAIL noe_high cyc%0d: got oe=%b%b%b want 000", i, oe1, oe2, oe3);
      end
    end
    // All strobes low is a write only.
    nCE = 1'b0; nWE = 1'b0; nOE = 1'b0; A = 7'h30; DI = 8'h77;
    @(negedge CLK);
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({oe1, oe2, oe3} !== 3'b000 || do1 !== 8'h22) begin
        n_bad++; $display("FAIL wr_oe_low cyc%0d: got oe=%b%b%b do=%h want 000 do=22", i, oe1, oe2, oe3, do1);
      end
      @(negedge CLK);
    end
    nCE = 1'b1; nWE = 1'b1; nOE = 1'b0; A = 7'h30;
    @(negedge CLK);
    n_cmp++;
    if (oe1 !== 1'b0) begin
      n_bad++; $display("FAIL nce_high: got oe=%b want 0", oe1);
    end
    drive_read(7'h30); @(negedge CLK);
    drive_idle();
    n_cmp++;
    if (oe1 !== 1'b1 || do1 !== 8'h77) begin
      n_bad++; $display("FAIL wr_oe_low_readback: got oe=%b do=%h want oe=1 do=77", oe1, do1);
    end
    repeat (3) @(negedge CLK);
  endtask

`ifdef SRAM_CLEAR_EN
  task automatic test_sweep();
    int n;
    RESETB = 1'b1;
    n = 0;
    do begin
      @(negedge CLK); n++;
      if (n == 1) begin
        n_cmp++;
        if (dbg1 !== 1'b1 || rdy1 !== 1'b0) begin
          n_bad++; $display("FAIL sweep_state: got dbg=%b ready=%b want 1/0", dbg1, rdy1);
        end
      end
    end while (!rdy1 && n < 300);
    n_cmp++;
    if (n !== 128) begin
      n_bad++; $display("FAIL sweep_len: got %0d edges want 128", n);
    end
    n_cmp++;
    if ({rdy2, rdy3} !== 2'b11) begin
      n_bad++; $display("FAIL sweep_ready_all: got %b%b want 11", rdy2, rdy3);
    end
    for (int a = 0; a < 128; a++) begin
      drive_read(AW'(a)); @(negedge CLK);
      n_cmp++;
      if (oe1 !== 1'b1 || do1 !== 8'h5A) begin
        n_bad++; $display("FAIL fill_read @%h: got oe=%b do=%h want oe=1 do=5a", a, oe1, do1);
      end
    end
    drive_idle();
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_clear();
    int n;
    RESETB = 1'b0; @(negedge CLK);
    RESETB = 1'b1;
    repeat (64) @(negedge CLK);
    RESETB = 1'b0; #1;
    n_cmp++;
    if (rdy1 !== 1'b0 || dbg1 !== 1'b1) begin
      n_bad++; $display("FAIL midsweep_reset: got ready=%b dbg=%b want 0/1", rdy1, dbg1);
    end
    @(negedge CLK);
    RESETB = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!rdy1 && n < 300);
    n_cmp++;
    if (n !== 128) begin
      n_bad++; $display("FAIL resweep_len: got %0d edges want 128", n);
    end
    drive_write(7'h05, 8'h99); @(negedge CLK);
    drive_read(7'h05);         @(negedge CLK);
    drive_idle(); CLR = 1'b1;  @(negedge CLK);
    CLR = 1'b0;
    n_cmp++;
    if ({rdy1, rdy2, rdy3} !== 3'b000) begin
      n_bad++; $display("FAIL clr_ready: got %b%b%b want 000", rdy1, rdy2, rdy3);
    end
    n_cmp++;
    if ({oe1, oe2, oe3} !== 3'b000) begin
      n_bad++; $display("FAIL clr_flush: got oe=%b%b%b want 000", oe1, oe2, oe3);
    end
    n = 0;
    do begin
      CLR = (n == 10);
      @(negedge CLK); n++;
      n_cmp++;
      if (oe3 !== 1'b0) begin
        n_bad++; $display("FAIL clr_flush_lat3 edge%0d: got oe=%b want 0", n, oe3);
      end
    end while (!rdy1 && n < 300);
    CLR = 1'b0;
    n_cmp++;
    if (n !== 128) begin
      n_bad++; $display("FAIL clr_sweep_len: got %0d edges want 128", n);
    end
    drive_read(7'h05); @(negedge CLK);
    drive_read(7'h12); @(negedge CLK);
    drive_idle();
    n_cmp++;
    if (oe2 !== 1'b1 || do2 !== 8'h00) begin
      n_bad++; $display("FAIL clr_fill_05: got oe=%b do=%h want oe=1 do=00", oe2, do2);
    end
    @(negedge CLK);
    n_cmp++;
    if (oe2 !== 1'b1 || do2 !== 8'h00) begin
      n_bad++; $display("FAIL clr_fill_12: got oe=%b do=%h want oe=1 do=00", oe2, do2);
    end
    repeat (3) @(negedge CLK);
  endtask
`else
  task automatic test_no_clear();
    RESETB = 1'b1; #1;
    n_cmp++;
    if ({rdy1, rdy2, rdy3} !== 3'b111 || dbg1 !== 1'b0) begin
      n_bad++; $display("FAIL noclr_ready: got %b%b%b dbg=%b want 111 dbg=0", rdy1, rdy2, rdy3, dbg1);
    end
    drive_write(7'h3C, 8'h6B); CLR = 1'b1; @(negedge CLK);
    CLR = 1'b0;
    n_cmp++;
    if (rdy1 !== 1'b1) begin
      n_bad++; $display("FAIL noclr_clr_ignored: got ready=%b want 1", rdy1);
    end
    drive_read(7'h3C); CLR = 1'b1; @(negedge CLK);
    drive_idle(); CLR = 1'b0;
    n_cmp++;
    if (oe1 !== 1'b1 || do1 !== 8'h6B) begin
      n_bad++; $display("FAIL noclr_read_3c: got oe=%b do=%h want oe=1 do=6b", oe1, do1);
    end
    repeat (3) @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
`ifdef SRAM_CLEAR_EN
    test_sweep();
`else
    test_no_clear();
`endif
    test_rd_lat1();
    test_back_to_back();
    test_collision();
`ifdef SRAM_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
